// File: rtl/pe_pkg.sv
// Shared definitions for the weight-stationary systolic PE row.
//   pe_state_t / ST_*   : 2-bit FSM state encoding (IDLE, LOAD, RUN)
//   acc_width()         : internal accumulator width so that no product or
//                         partial sum can overflow
//   fmt_result()        : maps an accumulator value onto the output width,
//                         either clamping (sat_en=1) or wrapping (sat_en=0)
package pe_pkg;

  typedef logic [1:0] pe_state_t;

  localparam pe_state_t ST_IDLE = 2'd0;
  localparam pe_state_t ST_LOAD = 2'd1;
  localparam pe_state_t ST_RUN  = 2'd2;

  function automatic int acc_width(input int data_w, input int weight_w,
                                   input int num_taps);
    return data_w + weight_w + $clog2(num_taps);
  endfunction

  // Works on a 64-bit container; the caller narrows the result to out_w bits.
  function automatic logic [63:0] fmt_result(input logic [63:0] acc,
                                             input int out_w,
                                             input logic sat_en);
    logic [63:0] max_v;
    max_v = (64'd1 << out_w) - 64'd1;
    if (sat_en && (acc > max_v)) begin
      return max_v;
    end
    return acc & max_v;
  endfunction

endpackage

// File: rtl/pe_cell.sv
// One tap of the transposed-form row.
//   w_q  : stationary weight, written when w_we is high, cleared only by reset
//   r_out: pipeline register holding w*x + r_in, loaded when en is high,
//          cleared by reset or clr (pipeline flush on reconfiguration)
// Ports:
//   clk, rstn (sync, active-low), w_we, w_in, en, clr, x, r_in, r_out
module pe_cell
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACC_W        = 14
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    w_we,
  input  logic [WEIGHT_WIDTH-1:0] w_in,
  input  logic                    en,
  input  logic                    clr,
  input  logic [DATA_WIDTH-1:0]   x,
  input  logic [ACC_W-1:0]        r_in,
  output logic [ACC_W-1:0]        r_out
);

  logic [WEIGHT_WIDTH-1:0] w_q;
  logic [ACC_W-1:0]        prod;
  logic [ACC_W-1:0]        sum;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_q <= '0;
    end else if (w_we) begin
      w_q <= w_in;
    end
  end

  // Operands are widened first so the multiply and add happen at ACC_W bits.
  always_comb begin
    prod = ACC_W'(w_q) * ACC_W'(x);
    sum  = prod + r_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out <= '0;
    end else if (clr) begin
      r_out <= '0;
    end else if (en) begin
      r_out <= sum;
    end
  end

endmodule

// File: rtl/pe_row_systolic.sv
// Weight-stationary row of NUM_TAPS PEs in transposed (systolic) form,
// computing y[n] = sum_k w[k]*x[n-k].
// Weights are loaded serially after a cfg_load pulse; pixels and results
// stream through valid/ready handshakes.
//
// Handshake rule for every channel: a beat transfers on a rising clk edge
// where both valid and ready are high; a producer keeps valid and data
// stable until the transfer happens.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   cfg_load           pulse: go to LOAD, restart weight index, flush pipeline
//   w_valid/w_ready/w_data    weight beats (w_ready high only in LOAD)
//   in_valid/in_ready/in_data pixel stream (accepted only in RUN)
//   out_valid/out_ready/out_data result stream
//   running            high while in RUN
//
// Build option: define PE_ROW_SATURATE_EN to clamp results to
// 2**OUT_WIDTH-1; otherwise the low OUT_WIDTH bits are kept.
module pe_row_systolic
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 4,
  parameter int NUM_TAPS     = 3,
  parameter int OUT_WIDTH    = 12
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cfg_load,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [WEIGHT_WIDTH-1:0] w_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    running
);

  localparam int ACC_W = acc_width(DATA_WIDTH, WEIGHT_WIDTH, NUM_TAPS);
  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

`ifdef PE_ROW_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  pe_state_t        state;
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] warm;
  logic             w_accept;
  logic             adv;

  // r_chain[k] is the pipe register of tap k; the last entry is the constant
  // zero fed into the far end of the row.
  logic [ACC_W-1:0] r_chain [NUM_TAPS+1];

  assign w_ready  = (state == ST_LOAD);
  assign running  = (state == ST_RUN);
  // cfg_load takes priority over any beat presented in the same cycle.
  assign w_accept = w_valid & w_ready & ~cfg_load;
  assign in_ready = running & ~cfg_load & (~out_valid | out_ready);
  assign adv      = in_valid & in_ready;

  assign r_chain[NUM_TAPS] = '0;

  genvar k;
  generate
    for (k = 0; k < NUM_TAPS; k++) begin : g_tap
      pe_cell #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .ACC_W       (ACC_W)
      ) u_cell (
        .clk  (clk),
        .rstn (rstn),
        .w_we (w_accept && (widx == IDX_W'(k))),
        .w_in (w_data),
        .en   (adv),
        .clr  (cfg_load),
        .x    (in_data),
        .r_in (r_chain[k+1]),
        .r_out(r_chain[k])
      );
    end
  endgenerate

  // Tap 0's register is the output register: it only changes on adv, so the
  // result stays stable while the downstream stalls.
  assign out_data = OUT_WIDTH'(fmt_result(64'(r_chain[0]), OUT_WIDTH, SAT_EN));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      widx      <= '0;
      warm      <= '0;
      out_valid <= 1'b0;
    end else if (cfg_load) begin
      state     <= ST_LOAD;
      widx      <= '0;
      warm      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (w_accept) begin
            if (widx == LAST_IDX) begin
              widx  <= '0;
              state <= ST_RUN;
            end else begin
              widx <= widx + IDX_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (adv) begin
            // The first NUM_TAPS-1 pixels only prime the pipe.
            out_valid <= (warm == LAST_IDX);
            if (warm != LAST_IDX) begin
              warm <= warm + IDX_W'(1);
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_row_systolic.sv
module tb_pe_row_systolic;

  localparam int DATA_WIDTH   = 8;
  localparam int WEIGHT_WIDTH = 4;
  localparam int NUM_TAPS     = 3;
  localparam int OUT_WIDTH    = 12;
  localparam longint unsigned OUT_MAX = (64'd1 << OUT_WIDTH) - 64'd1;

`ifdef PE_ROW_SATURATE_EN
  localparam logic SAT_REF = 1'b1;
  localparam int   SAT_EXP = 4095;
`else
  localparam logic SAT_REF = 1'b0;
  localparam int   SAT_EXP = 3283;
`endif

  logic                    clk;
  logic                    rstn;
  logic                    cfg_load;
  logic                    w_valid;
  logic                    w_ready;
  logic [WEIGHT_WIDTH-1:0] w_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_WIDTH-1:0]    out_data;
  logic                    running;

  int checks = 0;
  int errors = 0;

  logic [OUT_WIDTH-1:0] exp_q[$];
  int unsigned          hist[$];
  int unsigned          w_model[NUM_TAPS];

  logic ready_rand = 1'b0;
  logic ready_val  = 1'b1;
  logic rnd_ready  = 1'b1;
  assign out_ready = ready_rand ? rnd_ready : ready_val;

  logic                 hold_prev = 1'b0;
  logic [OUT_WIDTH-1:0] hold_val  = '0;
  logic [OUT_WIDTH-1:0] mon_e;

  pe_row_systolic #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .NUM_TAPS    (NUM_TAPS),
    .OUT_WIDTH   (OUT_WIDTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cfg_load (cfg_load),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .running  (running)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: direct convolution over the pixels seen since the last load.
  function automatic logic [OUT_WIDTH-1:0] model_out();
    longint unsigned y;
    int n;
    y = 0;
    n = hist.size();
    for (int j = 0; j < NUM_TAPS; j++) begin
      y += longint'(w_model[j]) * longint'(hist[n-1-j]);
    end
    if (SAT_REF && (y > OUT_MAX)) return OUT_WIDTH'(OUT_MAX);
    return OUT_WIDTH'(y % (OUT_MAX + 1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rstn = 1'b0; cfg_load = 1'b0; w_valid = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    hist.delete();
    step();
    rstn = 1'b1;
  endtask

  task automatic load_w(input int unsigned a, input int unsigned b, input int unsigned c);
    w_model[0] = a; w_model[1] = b; w_model[2] = c;
    in_valid = 1'b0; w_valid = 1'b0;
    cfg_load = 1'b1;
    hist.delete();
    step();
    cfg_load = 1'b0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      w_valid = 1'b1;
      w_data  = WEIGHT_WIDTH'(w_model[i]);
      @(negedge clk);
      chk("w_ready_load", w_ready, 1);
      chk("in_ready_load", in_ready, 0);
      step();
    end
    w_valid = 1'b0;
    @(negedge clk);
    chk("running_after_load", running, 1);
    step();
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  // with in_valid still high, so the caller chains or drops it.
  task automatic send(input int unsigned x);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = DATA_WIDTH'(x);
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        hist.push_back(x);
        if (hist.size() >= NUM_TAPS) exp_q.push_back(model_out());
      end
      step();
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout pixel %0d got not_accepted required accepted", x);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    in_valid   = 1'b0;
    ready_rand = 1'b0;
    ready_val  = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (hold_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_val);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got %0d required no_output", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", out_data, mon_e);
      end
    end
    hold_prev = out_valid && !out_ready && rstn && !cfg_load;
    hold_val  = out_data;
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; cfg_load = 1'b0; w_valid = 1'b0; w_data = '0;
    in_valid = 1'b0; in_data = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_running", running, 0);
    step();
    rstn = 1'b1;

    // pixels offered in IDLE are refused
    in_valid = 1'b1; in_data = 8'd55;
    step();
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_running", running, 0);
    step();
    in_valid = 1'b0;

    // basic convolution and latency
    load_w(1, 2, 3);
    send(10); send(20);
    in_valid = 1'b0;
    @(negedge clk);
    chk("warmup_no_out", out_valid, 0);
    step();
    send(30);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_30_valid", out_valid, 1);
    chk("y_100", out_data, 100);
    step();
    send(40);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_40_valid", out_valid, 1);
    chk("y_160", out_data, 160);
    step();
    drain();

    // backpressure: result held, pixel stalls, nothing lost
    load_w(1, 2, 3);
    send(10); send(20);
    ready_val = 1'b0;
    send(30);
    in_data = 8'd40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_data", out_data, 100);
      step();
    end
    ready_val = 1'b1;
    send(40);
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_stall_160", out_data, 160);
    step();
    drain();

    // overflow formatting
    load_w(15, 15, 15);
    send(255); send(255); send(255);
    in_valid = 1'b0;
    @(negedge clk);
    chk("fmt_result", out_data, SAT_EXP);
    step();
    drain();

    // reconfigure mid-stream, including a pixel colliding with cfg_load
    load_w(1, 2, 3);
    send(5); send(6);
    in_valid = 1'b1; in_data = 8'd99; cfg_load = 1'b1;
    @(negedge clk);
    chk("cfg_blocks_pixel", in_ready, 0);
    step();
    cfg_load = 1'b0; in_valid = 1'b0;
    load_w(1, 0, 0);
    send(7); send(8);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rewarm_no_out", out_valid, 0);
    step();
    send(9);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rewarm_valid", out_valid, 1);
    chk("rewarm_y9", out_data, 9);
    step();
    drain();

    // reset while a result is being held
    load_w(1, 2, 3);
    ready_val = 1'b0;
    send(1); send(2); send(3);
    in_valid = 1'b0;
    step();
    do_reset();
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_w_ready", w_ready, 0);
    step();
    ready_val = 1'b1;
    in_valid = 1'b1; in_data = 8'd17;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    step();
    load_w(2, 1, 1);
    for (int i = 0; i < 6; i++) send($urandom_range(0, 255));
    drain();

    // weight beats during RUN are ignored
    load_w(3, 1, 2);
    for (int i = 0; i < 3; i++) begin
      w_valid = 1'b1;
      w_data  = WEIGHT_WIDTH'($urandom_range(0, 15));
      @(negedge clk);
      chk("run_w_ready", w_ready, 0);
      step();
    end
    w_valid = 1'b0;
    for (int i = 0; i < 10; i++) send($urandom_range(0, 255));
    drain();

    // randomized streams with random backpressure
    for (int r = 0; r < 6; r++) begin
      load_w($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      ready_rand = r[0];
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          step();
        end
        send($urandom_range(0, 255));
      end
      drain();
    end

    step();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
